paint_queue: RTL
================

# paint_queue

Buffered paint-command scheduler between game logic and the `render_box20` cell painter. It accepts cell-paint requests (column, row, colour) into a small FIFO and converts grid coordinates to pixel origins. It issues the requests one at a time to the painter over its start/busy/done handshake. It also owns the power-up and on-demand full-board clear, so callers never drive the painter directly.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `CLEAR_COLOR`, 9'h000: colour used for every full-board clear paint.
- `CLOCK_50`  in  1: system clock, 50 MHz.
- `resetn`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: paint request strobe.
- `req_x`  in  4: cell column, 0..9.
- `req_y`  in  5: cell row, 0..19.
- `req_color`  in  9: RGB 3-3-3 colour.
- `req_ready`  out  1: FIFO not full.
- `clear_all`  in  1: single-cycle request to flush the FIFO and repaint the whole board in `CLEAR_COLOR`.
- `start`  out  1: single-cycle pulse to the painter.
- `x0`  out  10: pixel x origin of the current paint.
- `y0`  out  9: pixel y origin of the current paint.
- `color`  out  9: colour of the current paint.
- `busy`  in  1: painter busy.
- `done`  in  1: painter single-cycle completion pulse.
- `clearing`  out  1: a full-board clear is in progress or pending.
- `idle`  out  1: FIFO empty, not clearing, and no paint outstanding.
- `level`  out  5: current FIFO occupancy, 0..DEPTH.
- `drop_err`  out  1: sticky flag set when a request is dropped.

## Operation
**State machine states:** CLEAR_ISSUE, CLEAR_WAIT, IDLE, ISSUE, WAIT.

**Coordinate conversion** (combinational on the selected cell, then registered into the outputs):
- `x0 = {x, 6'b0}` (x·64, maximum 576).
- `y0 = {y,4'b0} + {y,3'b0}` (y·24, maximum 456). No overflow is possible in 9 bits.

**Request acceptance:**
- A request is accepted when `req_valid & req_ready`, `req_x ≤ 9` and `req_y ≤ 19`.
- A request made while full, or with out-of-range coordinates, is discarded and sets `drop_err`.
- Requests are accepted in every state, including during a clear. They dispatch in FIFO order after the clear finishes.

**Clear sequence:**
- Raster order over 200 cells, x fastest: (0,0), (1,0) … (9,0), (0,1) … (9,19).
- Every cell is painted in `CLEAR_COLOR`.

**Transitions:**
- Reset → CLEAR_ISSUE with the clear cell set to (0,0).
- CLEAR_ISSUE: if `~busy`, pulse `start` with the clear cell → CLEAR_WAIT.
- CLEAR_WAIT: on `done`, advance the clear cell.
  - After cell (9,19): → IDLE.
  - Otherwise: → CLEAR_ISSUE.
- IDLE: if FIFO non-empty → ISSUE.
- ISSUE: if `~busy`, pop the head, pulse `start` → WAIT.
- WAIT: on `done`:
  - → IDLE if FIFO is empty.
  - Otherwise → ISSUE.
- WAIT and CLEAR_WAIT wait on `done` only and ignore `busy`, because `busy` may rise one cycle after `start`.

**`clear_all`:**
- Flushes the FIFO (`level` = 0 on the next edge) and clears `drop_err`.
- Latches a pending clear: `clearing` goes to 1 immediately on the next edge.
- From IDLE or ISSUE: → CLEAR_ISSUE at (0,0).
- From WAIT or CLEAR_WAIT: the in-flight paint completes on `done`, then → CLEAR_ISSUE at (0,0).
- During a clear: the clear restarts from (0,0).
- A request in the same cycle as `clear_all` is discarded without setting `drop_err`.

## Timing
**Reset values:**
- `start` = 0, `x0` = 0, `y0` = 0, `color` = 0, `level` = 0, `drop_err` = 0.
- `req_ready` = 1, `clearing` = 1, `idle` = 0.

**Reset behaviour:**
- Assertion mid-operation forces the reset values immediately; no `done` is awaited.
- After release, the clear starts from (0,0).

**Latency:**
- A request accepted at edge N into an empty FIFO, in IDLE with the painter idle:
  - edge N+1: ISSUE.
  - edge N+2: `start` = 1 for one cycle, with `x0`/`y0`/`color` registered on the same edge.
- After `done` at edge M with the FIFO non-empty: the next `start` at edge M+2.

**Handshake:**
- `x0`, `y0` and `color` are held stable from `start` until the cycle after `done`.
- `start` is never asserted while `busy` = 1 or while a paint is outstanding.

**FIFO:**
- `req_ready` = (`level` < DEPTH), registered.
- A simultaneous push and pop leaves `level` unchanged and is legal at any `level` below DEPTH.
- Pointers wrap modulo DEPTH.

**Flags:**
- `idle` is registered: 1 in IDLE with FIFO empty and no pending clear.
- `drop_err` is cleared only by reset or `clear_all`.

## Test plan
- **Reset clear:** release reset with a painter model (busy for 10 cycles, then `done`) → exactly 200 `start` pulses; the first at `x0`=0, `y0`=0; the last at `x0`=576, `y0`=456; all `color`=0. Then `clearing`=0 and `idle`=1.
- **Single paint:** after the clear, request (3,5,9'h1C7) → one `start` two edges after acceptance, with `x0`=192, `y0`=120, `color`=9'h1C7, held until `done`.
- **Overflow:** stall the painter in WAIT and push 9 requests back-to-back → `level`=8, `req_ready`=0, 9th dropped, `drop_err`=1. Then release the painter → 8 `start` pulses in push order.
- **Out of range:** request (10,0) and (0,20) → no `start`, `level` unchanged, `drop_err`=1.
- **Clear during activity:** `clear_all` with 3 requests queued and one in flight → in-flight `done` honoured, `level`=0 on the next edge, `drop_err`=0, then 200 clear paints starting at (0,0).
- **Reset mid-paint:** assert `resetn`=0 during WAIT → all outputs at reset values within the same cycle. After release, the clear restarts at (0,0).

Source files
------------

// File: rtl/paint_queue_if.sv
// paint_queue_if
// Request, painter-handshake and status signals of paint_queue.
//   slave  : the paint_queue side (takes requests, drives the painter).
//   master : the caller / painter-model side.
// Request : req_valid, req_x[3:0], req_y[4:0], req_color[8:0] -> req_ready
// Control : clear_all (single-cycle full-board clear request)
// Painter : start, x0[9:0], y0[8:0], color[8:0] -> busy, done
// Status  : clearing, idle, level[4:0], drop_err
interface paint_queue_if;
  logic       req_valid;
  logic [3:0] req_x;
  logic [4:0] req_y;
  logic [8:0] req_color;
  logic       req_ready;
  logic       clear_all;
  logic       start;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [8:0] color;
  logic       busy;
  logic       done;
  logic       clearing;
  logic       idle;
  logic [4:0] level;
  logic       drop_err;

  modport slave (
    input  req_valid, req_x, req_y, req_color, clear_all, busy, done,
    output req_ready, start, x0, y0, color, clearing, idle, level, drop_err
  );

  modport master (
    output req_valid, req_x, req_y, req_color, clear_all, busy, done,
    input  req_ready, start, x0, y0, color, clearing, idle, level, drop_err
  );
endinterface

// File: rtl/paint_queue.sv
// paint_queue
// Buffered cell-paint scheduler in front of the render_box20 painter.
// Requests (column, row, colour) are queued in a DEPTH-entry FIFO and issued
// one at a time over the painter's start/busy/done handshake, with grid
// coordinates converted to pixel origins (x*64, y*24). After reset, and on
// clear_all, the whole 10x20 board is repainted in CLEAR_COLOR in raster
// order before queued requests are served.
// Ports:
//   CLOCK_50 : system clock
//   resetn   : asynchronous active-low reset
//   bus      : paint_queue_if.slave (requests, painter handshake, status)
module paint_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [8:0]  CLEAR_COLOR = 9'h000
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  paint_queue_if.slave  bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  typedef enum logic [2:0] {CLEAR_ISSUE, CLEAR_WAIT, IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cx_q, cx_d;
  logic [4:0]    cy_q, cy_d;
  logic          restart_q, restart_d;
  logic          start_q, start_d;
  logic [9:0]    x0_q, x0_d;
  logic [8:0]    y0_q, y0_d;
  logic [8:0]    color_q, color_d;
  logic [4:0]    level_q, level_d;
  logic          ready_q, ready_d;
  logic          drop_err_q, drop_err_d;
  logic          clearing_q, clearing_d;
  logic          idle_q, idle_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [17:0]   mem_q [DEPTH];

  logic       in_range, req_live, push, pop, drop;
  logic [3:0] sel_x;
  logic [4:0] sel_y;
  logic [8:0] sel_c;
  logic [17:0] head;

  // A request coinciding with clear_all is discarded silently.
  assign req_live = bus.req_valid & ~bus.clear_all;
  assign in_range = (bus.req_x <= 4'd9) && (bus.req_y <= 5'd19);
  assign push     = req_live & ready_q & in_range;
  assign drop     = req_live & ~(ready_q & in_range);
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= {bus.req_x, bus.req_y, bus.req_color};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_err_d = drop_err_q | drop;
    if (bus.clear_all) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drop_err_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + 5'd1;
        2'b01:   level_d = level_q - 5'd1;
        default: level_d = level_q;
      endcase
    end
    ready_d = (level_d < DEPTH_L);
  end

  // restart_q records a clear_all that arrived while a paint was in flight;
  // the outstanding done is honoured before the clear restarts at (0,0).
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    restart_d = restart_q;
    start_d   = 1'b0;
    pop       = 1'b0;
    sel_x     = cx_q;
    sel_y     = cy_q;
    sel_c     = CLEAR_COLOR;

    case (state_q)
      CLEAR_ISSUE: begin
        if (bus.clear_all) begin
          cx_d = '0;
          cy_d = '0;
        end else if (!bus.busy) begin
          start_d = 1'b1;
          state_d = CLEAR_WAIT;
        end
      end
      CLEAR_WAIT: begin
        if (bus.done) begin
          restart_d = 1'b0;
          state_d   = CLEAR_ISSUE;
          if (restart_q || bus.clear_all) begin
            cx_d = '0;
            cy_d = '0;
          end else if (cx_q == 4'd9 && cy_q == 5'd19) begin
            state_d = IDLE;
          end else if (cx_q == 4'd9) begin
            cx_d = '0;
            cy_d = cy_q + 5'd1;
          end else begin
            cx_d = cx_q + 4'd1;
          end
        end else if (bus.clear_all) begin
          restart_d = 1'b1;
        end
      end
      IDLE: begin
        if (bus.clear_all) begin
          cx_d    = '0;
          cy_d    = '0;
          state_d = CLEAR_ISSUE;
        end else if (level_q != 5'd0) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.clear_all) begin
          cx_d    = '0;
          cy_d    = '0;
          state_d = CLEAR_ISSUE;
        end else if (!bus.busy) begin
          pop     = 1'b1;
          start_d = 1'b1;
          sel_x   = head[17:14];
          sel_y   = head[13:9];
          sel_c   = head[8:0];
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.done) begin
          restart_d = 1'b0;
          if (restart_q || bus.clear_all) begin
            cx_d    = '0;
            cy_d    = '0;
            state_d = CLEAR_ISSUE;
          end else if (level_q == 5'd0) begin
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else if (bus.clear_all) begin
          restart_d = 1'b1;
        end
      end
      default: begin
        cx_d      = '0;
        cy_d      = '0;
        restart_d = 1'b0;
        state_d   = CLEAR_ISSUE;
      end
    endcase

    x0_d    = x0_q;
    y0_d    = y0_q;
    color_d = color_q;
    if (start_d) begin
      x0_d    = {sel_x, 6'b0};
      y0_d    = {sel_y, 4'b0} + {1'b0, sel_y, 3'b0};
      color_d = sel_c;
    end

    clearing_d = (state_d == CLEAR_ISSUE) || (state_d == CLEAR_WAIT) || restart_d;
    idle_d     = (state_d == IDLE) && (level_d == 5'd0) && !clearing_d;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CLEAR_ISSUE;
      cx_q       <= '0;
      cy_q       <= '0;
      restart_q  <= 1'b0;
      start_q    <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      color_q    <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      drop_err_q <= 1'b0;
      clearing_q <= 1'b1;
      idle_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      restart_q  <= restart_d;
      start_q    <= start_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      color_q    <= color_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      drop_err_q <= drop_err_d;
      clearing_q <= clearing_d;
      idle_q     <= idle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign bus.start     = start_q;
  assign bus.x0        = x0_q;
  assign bus.y0        = y0_q;
  assign bus.color     = color_q;
  assign bus.level     = level_q;
  assign bus.req_ready = ready_q;
  assign bus.drop_err  = drop_err_q;
  assign bus.clearing  = clearing_q;
  assign bus.idle      = idle_q;

endmodule
